mul_result_unit: RTL and testbench

Downstream stage of the 32x32 signed radix-8 Booth multiplier. Accepts the multiplier's 67-bit sign-extended product through a valid/ready handshake and buffers it in a small FIFO. Checks it for 32-bit overflow and sign-extension consistency. Delivers it to the register-file write port as one or two 32-bit beats.

---
 rtl/mul_result_unit.sv | 138 +++++++++++++
 tb/tb_mul_result_unit.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_result_unit.sv
// Result stage behind the radix-8 Booth multiplier: buffers 67-bit products
// and streams them to the register-file write port as one or two 32-bit beats.
module mul_result_unit #(
    parameter int DEPTH  = 2,
    parameter bit SAT_EN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        prod_valid,
    input  logic [66:0] prod_data,
    input  logic        prod_mode,
    output logic        prod_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        out_ovf,
    output logic        out_err,
    input  logic        out_ready,
    output logic        busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI
    } state_t;

    logic [63:0]      mem_data [DEPTH];
    logic [DEPTH-1:0] mem_mode;
    logic [DEPTH-1:0] mem_ovf;
    logic [DEPTH-1:0] mem_err;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    state_t        state;

    logic        push;
    logic        pop;
    logic        in_ovf;
    logic        in_err;
    logic [63:0] head_data;
    logic        head_mode;
    logic        head_ovf;
    logic        head_err;

    // Fits in 32-bit signed only if bits 66:31 are a pure sign extension.
    assign in_ovf = ~((&prod_data[66:31]) | ~(|prod_data[66:31]));
    assign in_err = ~((&prod_data[66:63]) | ~(|prod_data[66:63]));

    assign prod_ready = count < CW'(DEPTH);
    assign push       = prod_valid & prod_ready;
    assign pop        = out_valid & out_ready & out_last;
    assign busy       = count != '0;
    assign out_valid  = state != IDLE;

    assign head_data = mem_data[rd_ptr];
    assign head_mode = mem_mode[rd_ptr];
    assign head_ovf  = mem_ovf[rd_ptr];
    assign head_err  = mem_err[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= prod_data[63:0];
            mem_mode[wr_ptr] <= prod_mode;
            mem_ovf[wr_ptr]  <= in_ovf;
            mem_err[wr_ptr]  <= in_err;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // The next state ignores a same-cycle push, so a fresh product always
    // waits one cycle in the FIFO before it is presented.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (busy) state <= LO;
                LO: begin
                    if (out_ready) begin
                        if (!head_mode)
                            state <= HI;
                        else
                            state <= (count > CW'(1)) ? LO : IDLE;
                    end
                end
                HI: begin
                    if (out_ready)
                        state <= (count > CW'(1)) ? LO : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        out_ovf  = 1'b0;
        out_err  = 1'b0;
        case (state)
            LO: begin
                out_data = head_data[31:0];
                if (SAT_EN && head_mode && head_ovf)
                    out_data = head_data[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                out_last = head_mode;
                out_ovf  = head_ovf;
                out_err  = head_err;
            end
            HI: begin
                out_data = head_data[63:32];
                out_last = 1'b1;
                out_ovf  = head_ovf;
                out_err  = head_err;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mul_result_unit.sv
// Bench for mul_result_unit: directed product cases plus a randomized
// stream scored against a queue-based model of the expected beats.
module tb_mul_result_unit;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        prod_valid;
    logic [66:0] prod_data;
    logic        prod_mode;
    logic        out_ready;

    logic        prod_ready, out_valid, out_last, out_ovf, out_err, busy;
    logic [31:0] out_data;
    logic        prod_ready0, out_valid0, out_last0, out_ovf0, out_err0, busy0;
    logic [31:0] out_data0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul_result_unit #(.DEPTH(2), .SAT_EN(1'b1)) dut (
        .clk(clk), .rst_b(rst_b),
        .prod_valid(prod_valid), .prod_data(prod_data),
        .prod_mode(prod_mode), .prod_ready(prod_ready),
        .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ovf(out_ovf), .out_err(out_err),
        .out_ready(out_ready), .busy(busy)
    );

    mul_result_unit #(.DEPTH(2), .SAT_EN(1'b0)) dut0 (
        .clk(clk), .rst_b(rst_b),
        .prod_valid(prod_valid), .prod_data(prod_data),
        .prod_mode(prod_mode), .prod_ready(prod_ready0),
        .out_valid(out_valid0), .out_data(out_data0),
        .out_last(out_last0), .out_ovf(out_ovf0), .out_err(out_err0),
        .out_ready(out_ready), .busy(busy0)
    );

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d0;
        bit          last;
        bit          ovf;
        bit          err;
    } beat_t;

    typedef struct {
        logic [66:0] d;
        bit          mode;
        logic [31:0] lo1;
        logic [31:0] lo0;
        logic [31:0] hi;
        bit          ovf;
        bit          err;
    } vec_t;

    beat_t q[$];
    int    cnt = 0;

    // Expected beats from the arithmetic meaning of the product.
    task automatic model_push(input logic [66:0] d, input bit mode);
        beat_t  b;
        bit     err;
        bit     ovf;
        longint v;
        err = !(d[66:63] == 4'h0 || d[66:63] == 4'hF);
        v   = $signed(d[63:0]);
        ovf = err || v > 64'sd2147483647 || v < -64'sd2147483648;
        b.ovf = ovf;
        b.err = err;
        b.d0  = d[31:0];
        if (mode) begin
            b.last = 1'b1;
            b.d1   = ovf ? (d[63] ? 32'h8000_0000 : 32'h7FFF_FFFF) : d[31:0];
            q.push_back(b);
        end else begin
            b.last = 1'b0;
            b.d1   = d[31:0];
            q.push_back(b);
            b.last = 1'b1;
            b.d0   = d[63:32];
            b.d1   = d[63:32];
            q.push_back(b);
        end
    endtask

    function automatic logic [66:0] gen();
        logic [31:0] r;
        logic [63:0] r64;
        logic [66:0] d;
        r   = $urandom;
        r64 = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: d = {{35{r[31]}}, r};
            1: d = {{3{r64[63]}}, r64};
            2: d = {r[2:0], r64};
            default: begin
                case (r[1:0])
                    2'd0:    d = 67'h0_0000_0000_7FFF_FFFF;
                    2'd1:    d = 67'h7_FFFF_FFFF_8000_0000;
                    2'd2:    d = 67'h0_0000_0000_8000_0000;
                    default: d = 67'h7_FFFF_FFFF_7FFF_FFFF;
                endcase
            end
        endcase
        return d;
    endfunction

    task automatic idle_cycles(input int n);
        prod_valid = 1'b0;
        out_ready  = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_b      = 1'b0;
        prod_valid = 1'b0;
        prod_data  = '0;
        prod_mode  = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: valid=%b data=%h last=%b want 0", out_valid, out_data, out_last);
        end
        checks++;
        if (out_ovf !== 1'b0 || out_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: ovf=%b err=%b want 0", out_ovf, out_err);
        end
        checks++;
        if (busy !== 1'b0 || prod_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctl: busy=%b ready=%b want 0/1", busy, prod_ready);
        end
        rst_b = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_values();
        vec_t tv[7];
        tv[0] = '{67'd6, 1'b0, 32'h6, 32'h6, 32'h0, 1'b0, 1'b0};
        tv[1] = '{67'h7_FFFF_FFFF_FFFF_FFFD, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tv[2] = '{67'h0_0000_0000_8000_0000, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 1'b1, 1'b0};
        tv[3] = '{67'h2_1234_5678_9ABC_DEF0, 1'b0, 32'h9ABC_DEF0, 32'h9ABC_DEF0, 32'h1234_5678, 1'b1, 1'b1};
        tv[4] = '{67'h7_FFFF_FFFF_7FFF_FFFF, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0};
        tv[5] = '{67'h7_FFFF_FFFF_8000_0000, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b0, 1'b0};
        tv[6] = '{67'h0_0000_0000_7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b0};
        out_ready = 1'b1;
        foreach (tv[i]) begin
            prod_valid = 1'b1;
            prod_data  = tv[i].d;
            prod_mode  = tv[i].mode;
            @(posedge clk);
            #1;
            prod_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL latency[%0d]: valid=%b busy=%b want 0/1", i, out_valid, busy);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== tv[i].lo1 || out_data0 !== tv[i].lo0 ||
                out_last !== tv[i].mode) begin
                failures++;
                $display("FAIL beat0[%0d]: v=%b d=%h d0=%h l=%b want 1 %h %h %b",
                         i, out_valid, out_data, out_data0, out_last,
                         tv[i].lo1, tv[i].lo0, tv[i].mode);
            end
            checks++;
            if (out_ovf !== tv[i].ovf || out_err !== tv[i].err) begin
                failures++;
                $display("FAIL flags0[%0d]: ovf=%b err=%b want %b %b",
                         i, out_ovf, out_err, tv[i].ovf, tv[i].err);
            end
            if (!tv[i].mode) begin
                @(posedge clk);
                #1;
                checks++;
                if (out_valid !== 1'b1 || out_data !== tv[i].hi || out_data0 !== tv[i].hi ||
                    out_last !== 1'b1 || out_ovf !== tv[i].ovf || out_err !== tv[i].err) begin
                    failures++;
                    $display("FAIL beat1[%0d]: v=%b d=%h d0=%h l=%b o=%b e=%b want %h last=1 %b %b",
                             i, out_valid, out_data, out_data0, out_last, out_ovf, out_err,
                             tv[i].hi, tv[i].ovf, tv[i].err);
                end
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || out_ovf !== 1'b0) begin
                failures++;
                $display("FAIL drain[%0d]: valid=%b busy=%b ovf=%b want 0", i, out_valid, busy, out_ovf);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] want[6];
        logic [31:0] got[6];
        int n;
        int push_k;
        bool_dummy: begin end
        want = '{32'd11, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd5, 32'd1};
        n      = 0;
        push_k = -1;
        out_ready  = 1'b0;
        prod_mode  = 1'b0;
        prod_valid = 1'b1;
        prod_data  = 67'd11;
        @(posedge clk);
        #1;
        prod_data = 67'h7_FFFF_FFFF_FFFF_FFF0;
        @(posedge clk);
        #1;
        checks++;
        if (prod_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready: prod_ready=%b want 0", prod_ready);
        end
        prod_data = 67'h0_0000_0001_0000_0005;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'd11 || out_last !== 1'b0 ||
                prod_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: v=%b d=%h l=%b rdy=%b want 1 0000000b 0 0",
                         k, out_valid, out_data, out_last, prod_ready);
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid && out_ready && n < 6) begin
                got[n] = out_data;
                n++;
            end
            if (prod_valid && prod_ready && push_k < 0) push_k = k;
            @(posedge clk);
            #1;
            if (push_k >= 0) prod_valid = 1'b0;
        end
        checks++;
        if (n != 6) begin
            failures++;
            $display("FAIL stall_count: beats=%0d want 6", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                failures++;
                $display("FAIL stall_order[%0d]: got %h want %h", i, got[i], want[i]);
            end
        end
        checks++;
        if (push_k != 2) begin
            failures++;
            $display("FAIL stall_push: third push at cycle %0d want 2", push_k);
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid();
        out_ready  = 1'b0;
        prod_mode  = 1'b0;
        prod_valid = 1'b1;
        prod_data  = 67'd7;
        @(posedge clk);
        #1;
        prod_data = 67'd8;
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
        out_ready  = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_last !== 1'b1 || busy !== 1'b1 || prod_ready !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset_hi: v=%b l=%b busy=%b rdy=%b want 1 1 1 0",
                     out_valid, out_last, busy, prod_ready);
        end
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0 ||
            out_ovf !== 1'b0 || out_err !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_out: v=%b d=%h l=%b o=%b e=%b want 0",
                     out_valid, out_data, out_last, out_ovf, out_err);
        end
        checks++;
        if (prod_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_ctl: rdy=%b busy=%b want 1 0", prod_ready, busy);
        end
        @(posedge clk);
        #1;
        rst_b      = 1'b1;
        out_ready  = 1'b1;
        prod_valid = 1'b1;
        prod_data  = 67'd5;
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd5 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_lo: v=%b d=%h l=%b want 1 00000005 0", out_valid, out_data, out_last);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd0 || out_last !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_hi: v=%b d=%h l=%b want 1 00000000 1", out_valid, out_data, out_last);
        end
        idle_cycles(2);
    endtask

    task automatic test_random();
        beat_t b;
        q.delete();
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            if (i < 560) begin
                prod_valid = ($urandom_range(0, 3) != 0);
                prod_data  = gen();
                prod_mode  = $urandom_range(0, 1) == 1;
                out_ready  = ($urandom_range(0, 3) != 0);
            end else begin
                prod_valid = 1'b0;
                out_ready  = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (prod_ready !== (cnt < 2) || busy !== (cnt != 0)) begin
                failures++;
                $display("FAIL rnd_ctl[%0d]: rdy=%b busy=%b model_count=%0d", i, prod_ready, busy, cnt);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_spurious[%0d]: beat %h with empty model", i, out_data);
                end else begin
                    b = q.pop_front();
                    if (out_data !== b.d1 || out_data0 !== b.d0 || out_last !== b.last ||
                        out_ovf !== b.ovf || out_err !== b.err) begin
                        failures++;
                        $display("FAIL rnd_beat[%0d]: d=%h d0=%h l=%b o=%b e=%b want %h %h %b %b %b",
                                 i, out_data, out_data0, out_last, out_ovf, out_err,
                                 b.d1, b.d0, b.last, b.ovf, b.err);
                    end
                    if (b.last) cnt--;
                end
            end
            if (prod_valid && prod_ready) begin
                model_push(prod_data, prod_mode);
                cnt++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rnd_drain: model beats left=%0d out_valid=%b want 0 0", q.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_values();
        test_stall();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
